sipo_rx: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/sipo_rx_if.sv | 32 +++
 rtl/rx_sync.sv | 19 +
 rtl/sipo_rx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame definitions: receiver states, frame length, parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int MAX_DATA_BITS = 9;

    // Bits on the wire for one frame; the transmitter uses the same expression.
    function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

    // Zero-extended payload does not disturb the XOR reduction.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sipo_rx_if.sv
// rtl/sipo_rx_if.sv - serial input and parallel result bundle of the UART receiver.
interface sipo_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_tick;
    logic                 rx_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 active_flag;

    modport master (
        input  sample_tick,
        input  rx_in,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output active_flag
    );

    modport slave (
        output sample_tick,
        output rx_in,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  active_flag
    );
endinterface

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - two-flop synchronizer for the idle-high serial line.
module rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - oversampling UART receiver with majority-vote bit recovery.
module sipo_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_TYP = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input logic       clock,
    input logic       reset,
    sipo_rx_if.master bus
);
    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W  = $clog2(DATA_BITS + 1);
    localparam logic [SCNT_W-1:0] MID_LO    = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] MID       = SCNT_W'(OVERSAMPLE / 2);
    localparam logic [SCNT_W-1:0] MID_HI    = SCNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic              PAR_ODD   = (PARITY_TYP != 0);

    logic                 rx_s;
    rx_state_t            state;
    logic [SCNT_W-1:0]    scnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 armed;
    logic                 samp_lo;
    logic                 samp_mid;
    logic                 par_vote;
    logic                 ferr_acc;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 active_q;
    logic                 vote;
    logic                 decide;
    logic                 wrap;

    rx_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.rx_in),
        .q     (rx_s)
    );

    // The third sample is taken live at the decision point.
    assign vote   = (samp_lo & samp_mid) | (samp_lo & rx_s) | (samp_mid & rx_s);
    assign decide = (scnt == MID_HI);
    assign wrap   = (scnt == SCNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            scnt     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            armed    <= 1'b0;
            samp_lo  <= 1'b0;
            samp_mid <= 1'b0;
            par_vote <= 1'b0;
            ferr_acc <= 1'b0;
            shreg    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.sample_tick) begin
                if (state == IDLE) begin
                    // Arming on a high line keeps a held-low break from retriggering.
                    if (armed && !rx_s) begin
                        state    <= START;
                        scnt     <= '0;
                        active_q <= 1'b1;
                        armed    <= 1'b0;
                        ferr_acc <= 1'b0;
                    end else if (rx_s) begin
                        armed <= 1'b1;
                    end
                end else begin
                    scnt <= wrap ? '0 : scnt + 1'b1;
                    if (scnt == MID_LO) samp_lo <= rx_s;
                    if (scnt == MID) samp_mid <= rx_s;
                    case (state)
                        START: begin
                            if (decide && vote) begin
                                state    <= IDLE;
                                active_q <= 1'b0;
                            end else if (wrap) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end
                        end
                        DATA: begin
                            if (decide) shreg <= {vote, shreg[DATA_BITS-1:1]};
                            if (wrap) begin
                                if (bit_idx == IDX_LAST) begin
                                    state    <= (PARITY_EN != 0) ? PARITY : STOP;
                                    stop_idx <= 1'b0;
                                end else begin
                                    bit_idx <= bit_idx + 1'b1;
                                end
                            end
                        end
                        PARITY: begin
                            if (decide) par_vote <= vote;
                            if (wrap) begin
                                state    <= STOP;
                                stop_idx <= 1'b0;
                            end
                        end
                        STOP: begin
                            // Last stop bit completes at mid-bit to leave margin for the next start edge.
                            if (decide) begin
                                if (stop_idx == STOP_LAST) begin
                                    state    <= IDLE;
                                    active_q <= 1'b0;
                                    valid_q  <= 1'b1;
                                    data_q   <= shreg;
                                    perr_q   <= (PARITY_EN != 0) &&
                                                (par_vote != calc_parity(MAX_DATA_BITS'(shreg), PAR_ODD));
                                    ferr_q   <= ferr_acc | ~vote;
                                end else begin
                                    ferr_acc <= ferr_acc | ~vote;
                                end
                            end
                            if (wrap) stop_idx <= 1'b1;
                        end
                        default: begin
                            state    <= IDLE;
                            active_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.parity_err  = perr_q;
    assign bus.frame_err   = ferr_q;
    assign bus.active_flag = active_q;

endmodule
